// File: rtl/rfft_pkg.sv
// Shared sizes, unload FSM state type and bit-reverse helper for the 256-point RFFT
// result banks.
package rfft_pkg;

    localparam int unsigned NPOINT  = 256;
    localparam int unsigned LOG2N   = 8;
    localparam int unsigned NBANK   = 4;
    localparam int unsigned BANK_AW = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } unload_state_t;

    function automatic logic [LOG2N-1:0] bitrev8(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rfft_unload_fifo.sv
// Small synchronous output FIFO holding {sample, frequency index, last flag}.
// The head entry is presented straight from the storage flops.
module rfft_unload_fifo
    import rfft_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic [LOG2N-1:0] din_index,
    input  logic             din_last,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LOG2N-1:0] dout_index,
    output logic             dout_last,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [LOG2N-1:0] mem_idx  [DEPTH];
    logic             mem_last [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // A push into a full FIFO is only legal alongside a pop; the write lands in
    // the slot being vacated, which becomes the new tail.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
                mem_last[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= din;
                mem_idx[wr_ptr]  <= din_index;
                mem_last[wr_ptr] <= din_last;
                wr_ptr           <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout       = mem_data[rd_ptr];
    assign dout_index = mem_idx[rd_ptr];
    assign dout_last  = mem_last[rd_ptr];

endmodule

// File: rtl/rfft_unload.sv
// Reads the 256 RFFT results out of the four result banks in natural (or raw)
// order and streams them over valid/ready with index and last tags.
module rfft_unload
    import rfft_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BITREV     = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   ram_out0,
    input  logic [WIDTH-1:0]   ram_out1,
    input  logic [WIDTH-1:0]   ram_out2,
    input  logic [WIDTH-1:0]   ram_out3,
    output logic [BANK_AW-1:0] addr0,
    output logic [BANK_AW-1:0] addr1,
    output logic               re,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [LOG2N-1:0]   dout_index,
    output logic               dout_last,
    output logic               busy,
    output logic               unload_done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = $clog2(NBANK);

    unload_state_t      state;
    logic [LOG2N-1:0]   k;
    logic [LOG2N-1:0]   pos;
    logic               issue;
    logic               pop;
    logic               re_d;
    logic [LOG2N-1:0]   k_d;
    logic [BW-1:0]      bank_d;
    logic [BANK_AW-1:0] addr_q;
    logic [WIDTH-1:0]   rd_data;
    logic [CW-1:0]      fifo_count;
    int unsigned        occupancy;
    int unsigned        limit;

    // A read issued now lands in the FIFO two edges later, so it may only go out
    // if the FIFO plus the read already in flight leaves room after this pop.
    always_comb begin
        pos       = (BITREV != 0) ? bitrev8(k) : k;
        occupancy = 32'(fifo_count) + 32'(re_d);
        limit     = FIFO_DEPTH + 32'(pop);
        issue     = (state == RUN) && (occupancy < limit);
    end

    assign re         = issue;
    assign addr0      = issue ? pos[BANK_AW-1:0] : addr_q;
    assign addr1      = addr0;
    assign dout_valid = (fifo_count != '0);
    assign pop        = dout_valid & dout_ready;

    always_comb begin
        rd_data = ram_out0;
        case (bank_d)
            2'd1:    rd_data = ram_out1;
            2'd2:    rd_data = ram_out2;
            2'd3:    rd_data = ram_out3;
            default: rd_data = ram_out0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            k           <= '0;
            re_d        <= 1'b0;
            k_d         <= '0;
            bank_d      <= '0;
            addr_q      <= '0;
            busy        <= 1'b0;
            unload_done <= 1'b0;
        end else begin
            re_d        <= issue;
            unload_done <= 1'b0;
            if (issue) begin
                k_d    <= k;
                bank_d <= pos[LOG2N-1:BANK_AW];
                addr_q <= pos[BANK_AW-1:0];
                k      <= k + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        k     <= '0;
                    end
                end
                RUN: begin
                    if (issue && (k == LOG2N'(NPOINT - 1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && dout_last) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        unload_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    rfft_unload_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk        (Clk),
        .Reset      (Reset),
        .push       (re_d),
        .din        (rd_data),
        .din_index  (k_d),
        .din_last   (k_d == LOG2N'(NPOINT - 1)),
        .pop        (pop),
        .dout       (dout),
        .dout_index (dout_index),
        .dout_last  (dout_last),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_rfft_unload.sv
// Bench for rfft_unload: a natural-order and a raw-order instance run in lockstep
// against a frequency-index reference model over synchronous bank memories.
module tb_rfft_unload;

    localparam int unsigned W = 32;

    logic Clk = 1'b0;
    logic Reset;
    logic start;
    logic dout_ready;

    logic [3:0][W-1:0] ro_n, ro_r;
    logic [5:0]        a0_n, a1_n, a0_r, a1_r;
    logic              re_n, re_r;
    logic [W-1:0]      dout_n, dout_r;
    logic              dv_n, dv_r, last_n, last_r, busy_n, busy_r, done_n, done_r;
    logic [7:0]        idx_n, idx_r;

    logic [W-1:0] mem [4][64];
    logic [W-1:0] cap [2][256];

    int errors = 0;
    int checks = 0;

    logic         sv [2], sl [2], sb [2], sd [2], sre [2];
    logic [W-1:0] sdat [2];
    logic [7:0]   sidx [2];
    logic [5:0]   sa0 [2], sa1 [2];

    typedef struct {
        int           k;
        logic [W-1:0] nat;
        logic [W-1:0] raw;
    } vec_t;
    vec_t tbl [7];

    always #5 Clk = ~Clk;

    rfft_unload #(.WIDTH(W), .BITREV(1), .FIFO_DEPTH(2)) dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .ram_out0(ro_n[0]), .ram_out1(ro_n[1]), .ram_out2(ro_n[2]), .ram_out3(ro_n[3]),
        .addr0(a0_n), .addr1(a1_n), .re(re_n),
        .dout(dout_n), .dout_valid(dv_n), .dout_ready(dout_ready),
        .dout_index(idx_n), .dout_last(last_n), .busy(busy_n), .unload_done(done_n)
    );

    rfft_unload #(.WIDTH(W), .BITREV(0), .FIFO_DEPTH(2)) dut_raw (
        .Clk(Clk), .Reset(Reset), .start(start),
        .ram_out0(ro_r[0]), .ram_out1(ro_r[1]), .ram_out2(ro_r[2]), .ram_out3(ro_r[3]),
        .addr0(a0_r), .addr1(a1_r), .re(re_r),
        .dout(dout_r), .dout_valid(dv_r), .dout_ready(dout_ready),
        .dout_index(idx_r), .dout_last(last_r), .busy(busy_r), .unload_done(done_r)
    );

    always @(posedge Clk) begin
        if (re_n) begin
            ro_n[0] <= mem[0][a0_n];
            ro_n[1] <= mem[1][a0_n];
            ro_n[2] <= mem[2][a1_n];
            ro_n[3] <= mem[3][a1_n];
        end
    end

    always @(posedge Clk) begin
        if (re_r) begin
            ro_r[0] <= mem[0][a0_r];
            ro_r[1] <= mem[1][a0_r];
            ro_r[2] <= mem[2][a1_r];
            ro_r[3] <= mem[3][a1_r];
        end
    end

    // Result k sits at storage position bitrev(k) (natural) or k (raw);
    // the top two position bits pick the bank, the low six the word.
    function automatic logic [W-1:0] model(input int k, input bit natural);
        int p;
        p = k;
        if (natural) begin
            p = 0;
            for (int b = 0; b < 8; b++) begin
                if (((k >> b) & 1) != 0) p = p | (1 << (7 - b));
            end
        end
        return mem[p / 64][p % 64];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        sv[0] = dv_n;    sv[1] = dv_r;
        sl[0] = last_n;  sl[1] = last_r;
        sb[0] = busy_n;  sb[1] = busy_r;
        sd[0] = done_n;  sd[1] = done_r;
        sre[0] = re_n;   sre[1] = re_r;
        sdat[0] = dout_n; sdat[1] = dout_r;
        sidx[0] = idx_n;  sidx[1] = idx_r;
        sa0[0] = a0_n; sa0[1] = a0_r;
        sa1[0] = a1_n; sa1[1] = a1_r;
    endtask

    task automatic chk_reset_outputs(input string tag);
        sample();
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_valid"}, 64'(sv[d]), 64'(0));
            chk({tag, "_busy"},  64'(sb[d]), 64'(0));
            chk({tag, "_done"},  64'(sd[d]), 64'(0));
            chk({tag, "_re"},    64'(sre[d]), 64'(0));
            chk({tag, "_dout"},  64'(sdat[d]), 64'(0));
            chk({tag, "_index"}, 64'(sidx[d]), 64'(0));
            chk({tag, "_last"},  64'(sl[d]), 64'(0));
            chk({tag, "_addr0"}, 64'(sa0[d]), 64'(0));
            chk({tag, "_addr1"}, 64'(sa1[d]), 64'(0));
        end
    endtask

    task automatic run_unload(input bit rand_ready, input int restart_at,
                              input int abort_beat, input bit check_timing);
        int           next_k [2];
        int           beats [2];
        int           dones [2];
        bit           stalled [2];
        logic [W-1:0] hd [2];
        logic [7:0]   hi [2];
        logic         hl [2];
        int           first_v, last_beat, done_t, stop_t;
        bit           finished;
        first_v = -1; last_beat = -1; done_t = -1; stop_t = -1; finished = 1'b0;
        for (int d = 0; d < 2; d++) begin
            next_k[d] = 0; beats[d] = 0; dones[d] = 0; stalled[d] = 1'b0;
            hd[d] = '0; hi[d] = '0; hl[d] = 1'b0;
        end
        for (int t = 0; t < 3000; t++) begin
            start      = (t == 0) || (t == restart_at);
            dout_ready = rand_ready ? ($urandom_range(1, 0) == 1) : 1'b1;
            sample();
            if (t == 0) chk("busy_before_start", 64'(sb[0]), 64'(0));
            if (t == 1) begin
                chk("busy_after_start", 64'(sb[0]), 64'(1));
                chk("first_re", 64'(sre[0]), 64'(1));
            end
            for (int d = 0; d < 2; d++) begin
                if (stalled[d]) begin
                    chk("stall_valid", 64'(sv[d]), 64'(1));
                    chk("stall_data",  64'(sdat[d]), 64'(hd[d]));
                    chk("stall_index", 64'(sidx[d]), 64'(hi[d]));
                    chk("stall_last",  64'(sl[d]), 64'(hl[d]));
                end
                if (sv[d] && d == 0 && first_v < 0) first_v = t;
                if (sv[d] && dout_ready) begin
                    chk("beat_index", 64'(sidx[d]), 64'(next_k[d]));
                    chk("beat_data",  64'(sdat[d]), 64'(model(next_k[d], d == 0)));
                    chk("beat_last",  64'(sl[d]), 64'(next_k[d] == 255));
                    if (next_k[d] < 256) cap[d][next_k[d]] = sdat[d];
                    if (d == 0) last_beat = t;
                    next_k[d]++;
                    beats[d]++;
                end
                stalled[d] = sv[d] && !dout_ready;
                hd[d] = sdat[d];
                hi[d] = sidx[d];
                hl[d] = sl[d];
                if (sd[d]) begin
                    dones[d]++;
                    if (d == 0 && done_t < 0) done_t = t;
                end
            end
            if (abort_beat >= 0 && beats[0] == abort_beat) begin
                #3;
                Reset = 1'b1;
                #1;
                chk_reset_outputs("midrun_reset");
                start      = 1'b0;
                dout_ready = 1'b0;
                #2;
                Reset = 1'b0;
                tick();
                return;
            end
            if (dones[0] > 0 && dones[1] > 0 && stop_t < 0) stop_t = t + 8;
            if (t == stop_t) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        start = 1'b0;
        chk("run_completed_in_budget", 64'(finished), 64'(1));
        for (int d = 0; d < 2; d++) begin
            chk("beat_count", 64'(beats[d]), 64'(256));
            chk("done_count", 64'(dones[d]), 64'(1));
            chk("busy_after_done", 64'(sb[d]), 64'(0));
        end
        if (check_timing) begin
            chk("first_valid_cycle", 64'(first_v), 64'(3));
            chk("last_beat_cycle",   64'(last_beat), 64'(258));
            chk("done_cycle",        64'(done_t), 64'(259));
        end
        tick();
    endtask

    initial begin
        Reset      = 1'b1;
        start      = 1'b0;
        dout_ready = 1'b0;
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 64; w++)
                mem[b][w] = W'((b << 8) | w);

        tbl[0] = '{k: 0,   nat: 32'h000, raw: 32'h000};
        tbl[1] = '{k: 1,   nat: 32'h200, raw: 32'h001};
        tbl[2] = '{k: 2,   nat: 32'h100, raw: 32'h002};
        tbl[3] = '{k: 3,   nat: 32'h300, raw: 32'h003};
        tbl[4] = '{k: 64,  nat: 32'h002, raw: 32'h100};
        tbl[5] = '{k: 128, nat: 32'h001, raw: 32'h200};
        tbl[6] = '{k: 255, nat: 32'h33F, raw: 32'h33F};

        repeat (3) tick();
        chk_reset_outputs("reset");
        #2;
        Reset = 1'b0;
        tick();

        // Full rate, natural and raw order side by side.
        run_unload(1'b0, -1, -1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("table_natural", 64'(cap[0][tbl[i].k]), 64'(tbl[i].nat));
            chk("table_raw",     64'(cap[1][tbl[i].k]), 64'(tbl[i].raw));
        end

        run_unload(1'b1, -1, -1, 1'b0);   // random backpressure
        run_unload(1'b0, 100, -1, 1'b1);  // second start while busy
        run_unload(1'b1, -1, 40, 1'b0);   // reset at beat 40
        run_unload(1'b1, -1, -1, 1'b0);   // fresh run after the reset

        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 64; w++)
                mem[b][w] = $urandom;
        run_unload(1'b1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
